// File: rtl/ps2_tx_pkg.sv
// ps2_tx_pkg: shared states, default timing and known command codes for the PS/2 host transmitter.
package ps2_tx_pkg;
  typedef enum logic [3:0] {
    IDLE, INHIBIT, REQ, WAIT_FE, DATA, PARITY, STOP, ACK, WAIT_IDLE, FAIL
  } tx_state_t;
  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_START_TIMEOUT_CYCLES = 750000;
  localparam int DEF_PACKET_TIMEOUT_CYCLES = 100000;
  localparam int DEF_MAX_RETRIES = 2;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_ECHO = 8'hEE;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizer with falling-edge detect on a third flop.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic fe
);
  logic [2:0] s;
  // Reset to the idle-high bus level so no false edge follows reset.
  always_ff @(posedge clk)
    if (rst) s <= 3'b111;
    else s <= {s[1:0], d};
  assign q = s[1];
  assign fe = s[2] & ~s[1];
endmodule

// File: rtl/ps2_cmd_sender.sv
// ps2_cmd_sender: host-to-device PS/2 command byte transmitter; PS2_TX_RETRY_EN enables automatic retries.
module ps2_cmd_sender
  import ps2_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
  parameter int PACKET_TIMEOUT_CYCLES = DEF_PACKET_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES = DEF_MAX_RETRIES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);
  localparam int CW = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT_CYCLES, PACKET_TIMEOUT_CYCLES)) + 1;
  // Inhibit plus the one-cycle request phase together hold the clock low INHIBIT_CYCLES cycles.
  localparam logic [CW-1:0] INH_END = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] START_END = CW'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] PKT_END = CW'(PACKET_TIMEOUT_CYCLES - 1);
  tx_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] data;
  logic par, clk_s, clk_fe, dat_s, dat_fe, keep, pkt_to;
  ps2_line_sync u_clk (.clk(CLOCK_50), .rst(reset), .d(ps2_clk_in), .q(clk_s), .fe(clk_fe));
  ps2_line_sync u_dat (.clk(CLOCK_50), .rst(reset), .d(ps2_dat_in), .q(dat_s), .fe(dat_fe));
`ifdef PS2_TX_RETRY_EN
  localparam logic [3:0] RTRY = 4'(MAX_RETRIES);
  logic [3:0] retry_cnt;
  always_ff @(posedge CLOCK_50)
    if (reset || (state == IDLE && cmd_valid)) retry_cnt <= '0;
    else if (state == FAIL) retry_cnt <= retry_cnt + 4'd1;
`else
  localparam int unused_max_retries = MAX_RETRIES;
`endif
  logic unused_dat_fe;
  assign unused_dat_fe = dat_fe;
  assign busy = state != IDLE;
  assign pkt_to = cnt == PKT_END;
  // One packet timer spans DATA through STOP, so those hand-offs keep the count.
  assign keep = (state == DATA && state_n == PARITY) || (state == PARITY && state_n == STOP);
  always_comb begin
    state_n = state;
    cmd_ready = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    done = 1'b0;
    error = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        state_n = cmd_valid ? INHIBIT : IDLE;
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        state_n = cnt == INH_END ? REQ : INHIBIT;
      end
      REQ: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = 1'b1;
        state_n = WAIT_FE;
      end
      WAIT_FE: begin
        ps2_dat_oe = 1'b1;
        state_n = clk_fe ? DATA : cnt == START_END ? FAIL : WAIT_FE;
      end
      DATA: begin
        ps2_dat_oe = ~data[idx];
        state_n = pkt_to ? FAIL : (clk_fe && idx == 3'd7) ? PARITY : DATA;
      end
      PARITY: begin
        ps2_dat_oe = ~par;
        state_n = pkt_to ? FAIL : clk_fe ? STOP : PARITY;
      end
      STOP: state_n = pkt_to ? FAIL : clk_fe ? ACK : STOP;
      ACK: state_n = dat_s ? FAIL : WAIT_IDLE;
      WAIT_IDLE: begin
        done = clk_s & dat_s;
        state_n = done ? IDLE : pkt_to ? FAIL : WAIT_IDLE;
      end
      FAIL: begin
`ifdef PS2_TX_RETRY_EN
        error = retry_cnt >= RTRY;
        state_n = error ? IDLE : INHIBIT;
`else
        error = 1'b1;
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      data <= '0;
      par <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state && !keep) ? '0 : cnt + 1'b1;
      idx <= state != DATA ? 3'd0 : idx + 3'(clk_fe);
      if (state == IDLE && cmd_valid) begin
        data <= cmd_data;
        par <= ~^cmd_data;
      end
    end
endmodule

// File: tb/tb_ps2_cmd_sender.sv
// tb_ps2_cmd_sender: device-side PS/2 BFM with a queue-based scoreboard for the command sender.
module tb_ps2_cmd_sender;
  localparam int H = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int EXP_PHASES = 3;
`else
  localparam int EXP_PHASES = 1;
`endif
  typedef struct {
    logic [9:0] frame;
    bit ok;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error;
  logic dev_clk = 1'b1, dev_dat = 1'b1;
  logic ps2_clk_in, ps2_dat_in;
  exp_t sb[$];
  int total = 0, bad = 0;
  int phases = 0, hi_run = 0, ov_run = 0, last_hi = 0, last_ov = 0, rel = 0, err_delay = -1;
  int fe_count = 0;
  bit silent = 0, nack = 0, abort = 0, bfm_active = 0;
  logic prev_oe = 1'b0;
  logic [9:0] frame, last_frame;
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;
  always #10 clk = ~clk;
  ps2_cmd_sender #(
    .INHIBIT_CYCLES(50), .START_TIMEOUT_CYCLES(200), .PACKET_TIMEOUT_CYCLES(2000), .MAX_RETRIES(2)
  ) dut (
    .CLOCK_50(clk), .reset(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in), .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .busy(busy), .done(done), .error(error)
  );
  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] d);
    bit got = 0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clk);
      got = cmd_ready;
    end
    if (!got) chk(0, "send_ready_timeout", 0, 1);
    cmd_data = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask
  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = sb.size() == 0 && !busy;
    end
    if (!ok) chk(0, "idle_timeout", 32'(sb.size()), 0);
  endtask
  task automatic expect_tx(input logic [9:0] f, input bit ok);
    exp_t e;
    e.frame = f;
    e.ok = ok;
    sb.push_back(e);
  endtask
  // Device model: clocks 11 falling edges, samples data on each rising edge, drives ACK at edge 11.
  initial begin
    forever begin
      @(negedge clk);
      if (!silent && !ps2_clk_oe && ps2_dat_oe) begin
        bfm_active = 1;
        repeat (5) @(negedge clk);
        fe_count = 0;
        for (int i = 1; i <= 11 && !abort; i++) begin
          if (i == 11) dev_dat = nack;
          dev_clk = 1'b0;
          fe_count = i;
          repeat (H) @(negedge clk);
          if (i <= 10) frame[i-1] = ps2_dat_in;
          dev_clk = 1'b1;
          repeat (H) @(negedge clk);
        end
        last_frame = frame;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        bfm_active = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (ps2_clk_oe) begin
      if (!prev_oe) begin
        phases++;
        hi_run = 0;
        ov_run = 0;
      end
      hi_run++;
      if (ps2_dat_oe) ov_run++;
    end else if (prev_oe) begin
      last_hi = hi_run;
      last_ov = ov_run;
      rel = 0;
    end else rel++;
    if (error) err_delay = rel;
    prev_oe = ps2_clk_oe;
  end
  always @(negedge clk) begin
    if (!rst && (done || error)) begin
      if (sb.size() == 0) chk(0, "unexpected_pulse", {30'd0, done, error}, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk(done == e.ok && error == !e.ok, "outcome", {30'd0, done, error}, {30'd0, e.ok, !e.ok});
        if (e.ok) chk(last_frame == e.frame, "frame", 32'(last_frame), 32'(e.frame));
        else chk(!ps2_clk_oe && !ps2_dat_oe, "oe_at_error", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
        @(negedge clk);
        chk(cmd_ready == 1'b1, "ready_after", 32'(cmd_ready), 1);
      end
    end
  end
  initial begin
    int ph0;
    bit hit;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(cmd_ready == 1'b1, "rst_ready", 32'(cmd_ready), 1);
    chk(busy == 1'b0, "rst_busy", 32'(busy), 0);
    chk(done == 1'b0 && error == 1'b0, "rst_pulses", {30'd0, done, error}, 0);
    chk(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b0, "rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    rst = 1'b0;
    // 0xED: bits LSB first 1,0,1,1,0,1,1,1; six ones -> parity 1; stop 1.
    expect_tx({1'b1, 1'b1, 8'hED}, 1);
    send(8'hED);
    wait_idle(5000);
    chk(last_hi == 50, "inhibit_len", 32'(last_hi), 50);
    chk(last_ov == 1, "req_overlap", 32'(last_ov), 1);
    expect_tx({1'b1, 1'b0, 8'h01}, 1);
    send(8'h01);
    wait_idle(5000);
    expect_tx({1'b1, 1'b1, 8'hFF}, 1);
    send(8'hFF);
    wait_idle(5000);
    silent = 1;
    ph0 = phases;
    expect_tx(10'd0, 0);
    send(8'hFF);
    wait_idle(5000);
    chk(err_delay == 200, "start_timeout", 32'(err_delay), 200);
    chk(phases - ph0 == EXP_PHASES, "inhibit_phases", 32'(phases - ph0), 32'(EXP_PHASES));
    silent = 0;
    nack = 1;
    expect_tx(10'd0, 0);
    send(8'h01);
    wait_idle(20000);
    nack = 0;
    fe_count = 0;
    send(8'hED);
    hit = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(negedge clk);
      hit = fe_count >= 4;
    end
    if (!hit) chk(0, "fe4_timeout", 32'(fe_count), 4);
    abort = 1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b0, "midrst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    chk(busy == 1'b0, "midrst_busy", 32'(busy), 0);
    chk(cmd_ready == 1'b1, "midrst_ready", 32'(cmd_ready), 1);
    rst = 1'b0;
    hit = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(negedge clk);
      hit = !bfm_active;
    end
    if (!hit) chk(0, "bfm_abort_timeout", 1, 0);
    abort = 0;
    expect_tx({1'b1, 1'b1, 8'hEE}, 1);
    send(8'hEE);
    wait_idle(5000);
    // 0x55 (four ones -> parity 1) held valid during the 0xED transfer must follow it.
    expect_tx({1'b1, 1'b1, 8'hED}, 1);
    expect_tx({1'b1, 1'b1, 8'h55}, 1);
    send(8'hED);
    cmd_data = 8'h55;
    cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    hit = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(negedge clk);
      hit = cmd_ready;
    end
    if (!hit) chk(0, "held_valid_timeout", 0, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_idle(5000);
    repeat (5) @(negedge clk);
    chk(sb.size() == 0, "sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
